verbus_arbiter: RTL

//  - Shares one single-port memory slave between the core's instruction bus (I) and data bus (D).
//  - Makes the Harvard core runnable on a single unified RAM: sits between the core's ibus/dbus

---
 rtl/verbus_arbiter_pkg.sv | 12 +
 rtl/verbus_arbiter_if.sv | 35 +++
 rtl/verbus_watchdog.sv | 33 +++
 rtl/verbus_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/verbus_arbiter_pkg.sv
// rtl/verbus_arbiter_pkg.sv - shared types and constants for the I/D memory arbiter
package verbus_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_INSTR, ARB_DATA} arb_state_t;

  localparam wstrobe_t WSTROBE_NONE = 4'b0000;
  localparam word_t    WORD_ZERO    = 32'h0000_0000;

endpackage

// File: rtl/verbus_arbiter_if.sv
// rtl/verbus_arbiter_if.sv - instruction, data and memory-slave handshake bundle
interface verbus_arbiter_if;
  import verbus_arbiter_pkg::*;

  logic     i_valid;
  word_t    i_address;
  logic     i_ready;
  word_t    i_rdata;

  logic     d_valid;
  word_t    d_address;
  wstrobe_t d_wstrobe;
  word_t    d_wdata;
  logic     d_ready;
  word_t    d_rdata;

  logic     m_valid;
  word_t    m_address;
  wstrobe_t m_wstrobe;
  word_t    m_wdata;
  logic     m_ready;
  word_t    m_rdata;

  // slave: the arbiter's view; master: the cores plus memory around it
  modport slave (
    input  i_valid, i_address, d_valid, d_address, d_wstrobe, d_wdata, m_ready, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_valid, m_address, m_wstrobe, m_wdata
  );

  modport master (
    output i_valid, i_address, d_valid, d_address, d_wstrobe, d_wdata, m_ready, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_valid, m_address, m_wstrobe, m_wdata
  );

endinterface

// File: rtl/verbus_watchdog.sv
// rtl/verbus_watchdog.sv - bus watchdog: counts stalled busy cycles, flags an abort
module verbus_watchdog #(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic done,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] count;

  // Saturates rather than wraps so a disabled watchdog never aliases back to LIMIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && !done && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

  assign expired = (TIMEOUT != 0) && busy && !done && (count == LIMIT);

endmodule

// File: rtl/verbus_arbiter.sv
// rtl/verbus_arbiter.sv - shares one memory slave between instruction and data masters
module verbus_arbiter
  import verbus_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  verbus_arbiter_if.slave   bus,
  input  logic              err_clear,
  output logic              err_timeout
);

  arb_state_t state;
  arb_state_t state_next;
  logic       expired;
  logic       complete;
  logic       wd_start;

  assign complete = bus.m_ready || expired;
  // No state is ever re-entered directly, so any change into a grant is a fresh transfer
  assign wd_start = (state_next != state) && (state_next != ARB_IDLE);

  verbus_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_start),
    .busy    (state != ARB_IDLE),
    .done    (bus.m_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (expired) begin
      err_timeout <= 1'b1;
    end else if (err_clear) begin
      err_timeout <= 1'b0;
    end
  end

  always_comb begin
    state_next    = state;
    bus.m_valid   = 1'b0;
    bus.m_address = WORD_ZERO;
    bus.m_wstrobe = WSTROBE_NONE;
    bus.m_wdata   = WORD_ZERO;
    bus.i_ready   = 1'b0;
    bus.i_rdata   = WORD_ZERO;
    bus.d_ready   = 1'b0;
    bus.d_rdata   = WORD_ZERO;
    unique case (state)
      ARB_IDLE: begin
        // Data wins a tie: a pending load/store stalls the whole pipeline
        if (bus.d_valid) begin
          state_next = ARB_DATA;
        end else if (bus.i_valid) begin
          state_next = ARB_INSTR;
        end
      end
      ARB_INSTR: begin
        bus.m_valid   = 1'b1;
        bus.m_address = bus.i_address;
        if (complete) begin
          bus.i_ready = 1'b1;
          bus.i_rdata = bus.m_ready ? bus.m_rdata : WORD_ZERO;
          state_next  = bus.d_valid ? ARB_DATA : ARB_IDLE;
        end
      end
      ARB_DATA: begin
        bus.m_valid   = 1'b1;
        bus.m_address = bus.d_address;
        bus.m_wstrobe = bus.d_wstrobe;
        bus.m_wdata   = bus.d_wdata;
        if (complete) begin
          bus.d_ready = 1'b1;
          bus.d_rdata = bus.m_ready ? bus.m_rdata : WORD_ZERO;
          state_next  = bus.i_valid ? ARB_INSTR : ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule
